bake_sequencer: RTL

- Sequencing controller for the bread-machine phase timer datapath.
- Timer datapath interface: 2-bit load/decrement select in, one-bit `timer_elapsed` (timer == 0) out.
- The block runs the recipe phases knead, rise and bake, drives the paddle motor, heating element and bell, and supports cancel, lid-open safety gating and a quick (no-rise) recipe.
- It sits beside the timer register in the top level and is the only driver of the actuator outputs.

---
 rtl/bread_pkg.sv | 40 ++++
 rtl/edge_detect.sv | 23 ++
 rtl/bake_sequencer.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/bread_pkg.sv
// Shared definitions for the bread-machine sequencer and its timer datapath.
package bread_pkg;

  // Timer tick rate in Hz; the phase durations below are expressed in ticks.
  localparam int unsigned FREQ = 1;

  localparam int unsigned CYC_15MIN = 15 * 60 * FREQ;
  localparam int unsigned CYC_2HR   = 2 * 60 * 60 * FREQ;
  localparam int unsigned CYC_25MIN = 25 * 60 * FREQ;

  // Timer command codes driven on timer_select.
  localparam logic [1:0] SEL_DEC   = 2'b00;
  localparam logic [1:0] SEL_15MIN = 2'b01;
  localparam logic [1:0] SEL_2HR   = 2'b10;
  localparam logic [1:0] SEL_25MIN = 2'b11;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 3'd0,
    KNEAD = 3'd1,
    RISE  = 3'd2,
    BAKE  = 3'd3,
    DONE  = 3'd4
  } state_e;

  // Load command issued on the first cycle of a timed phase.
  function automatic logic [1:0] load_sel(input state_e st);
    logic [1:0] sel;
    sel = SEL_DEC;
    case (st)
      KNEAD:   sel = SEL_15MIN;
      RISE:    sel = SEL_2HR;
      BAKE:    sel = SEL_25MIN;
      default: sel = SEL_DEC;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Rising-edge pulse generator. History resets to "high" so a level held
// through reset does not look like a fresh edge.
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic pulse
);

  logic prev_q;

  // Remember last cycle's level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= sig;
    end
  end

  assign pulse = sig & ~prev_q;

endmodule

// File: rtl/bake_sequencer.sv
// Recipe sequencer: knead -> (rise) -> bake -> done, driving the phase timer
// commands and the actuators. All outputs come straight from registers.
module bake_sequencer
  import bread_pkg::*;
#(
  parameter int unsigned BELL_CYCLES = 10,
  parameter int unsigned BELL_W      = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_button,
  input  logic               cancel_button,
  input  logic               quick_mode,
  input  logic               lid_open,
  input  logic               timer_elapsed,
  output logic [1:0]         timer_select,
  output logic               paddle_motor,
  output logic               heating_element,
  output logic               bell,
  output logic               busy,
  output logic [STATE_W-1:0] phase
);

  state_e            state_q, state_d;
  logic              quick_q, quick_d;
  logic [BELL_W-1:0] bell_cnt_q, bell_cnt_d;

  logic [1:0] sel_q, sel_d;
  logic       paddle_q, paddle_d;
  logic       heat_q, heat_d;
  logic       bell_q, bell_d;
  logic       busy_q, busy_d;

  logic start_pulse;
  logic elapsed_ok;

  edge_detect u_start_edge (
    .clk   (clk),
    .rst   (rst),
    .sig   (start_button),
    .pulse (start_pulse)
  );

  // A nonzero select marks the load cycle, where elapsed still shows the old timer value.
  assign elapsed_ok = timer_elapsed && (sel_q == SEL_DEC);

  // State, latched recipe option and bell counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      quick_q    <= 1'b0;
      bell_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      quick_q    <= quick_d;
      bell_cnt_q <= bell_cnt_d;
    end
  end

  // Phase sequencing; cancel overrides everything outside IDLE.
  always_comb begin
    state_d    = state_q;
    quick_d    = quick_q;
    bell_cnt_d = bell_cnt_q;
    if ((state_q != IDLE) && cancel_button) begin
      state_d    = IDLE;
      bell_cnt_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_pulse && !cancel_button) begin
            state_d = KNEAD;
            quick_d = quick_mode;
          end
        end
        KNEAD: begin
          if (elapsed_ok) begin
            state_d = quick_q ? BAKE : RISE;
          end
        end
        RISE: begin
          if (elapsed_ok) begin
            state_d = BAKE;
          end
        end
        BAKE: begin
          if (elapsed_ok) begin
            state_d    = DONE;
            bell_cnt_d = BELL_CYCLES[BELL_W-1:0];
          end
        end
        DONE: begin
          bell_cnt_d = bell_cnt_q - BELL_W'(1);
          if (bell_cnt_q == BELL_W'(1)) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Next output values, derived from the state being entered.
  always_comb begin
    sel_d    = SEL_DEC;
    if (state_d != state_q) begin
      sel_d = load_sel(state_d);
    end
    paddle_d = (state_d == KNEAD) && !lid_open;
    heat_d   = (state_d == BAKE);
    bell_d   = (state_d == DONE);
    busy_d   = (state_d != IDLE);
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q    <= SEL_DEC;
      paddle_q <= 1'b0;
      heat_q   <= 1'b0;
      bell_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      sel_q    <= sel_d;
      paddle_q <= paddle_d;
      heat_q   <= heat_d;
      bell_q   <= bell_d;
      busy_q   <= busy_d;
    end
  end

  assign timer_select    = sel_q;
  assign paddle_motor    = paddle_q;
  assign heating_element = heat_q;
  assign bell            = bell_q;
  assign busy            = busy_q;
  assign phase           = state_q;

endmodule
